// File: rtl/framebuffer_reader.sv
// Raster-order framebuffer fetch with credit-limited prefetch FIFO and frame sequencing.
// Optional macro UNDERFLOW_CNT_EN adds a saturating underflow_count output.
module framebuffer_reader #(
  parameter int IMG_W       = 800,
  parameter int IMG_H       = 600,
  parameter int ADDR_W      = 20,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [23:0]       mem_rdata,
  output logic [23:0]       pixel_stream_dout,
  output logic              pixel_stream_dout_valid,
  input  logic              pixel_stream_dout_ready,
  output logic              frame_done,
  output logic              busy
`ifdef UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_count
`endif
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t state, state_nxt;

  logic                   issue;
  logic                   frame_issued;
  logic [ADDR_W-1:0]      addr_cnt;
  logic [ADDR_W-1:0]      pix_cnt;
  logic [MEM_LATENCY-1:0] tag_pipe;
  logic                   push;
  logic                   pop;
  logic [23:0]            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          inflight;
  logic [CW:0]            credit_used;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaulting state_nxt first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = FETCH;
      FETCH:   if (frame_issued && !enable) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0 && fifo_count == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Credits are registered: a pop this cycle only frees a slot for next cycle's issue.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};

  always_comb begin
    busy         = (state != IDLE);
    issue        = (state == FETCH) && (credit_used < (CW+1)'(FIFO_DEPTH));
    frame_issued = issue && (addr_cnt == LAST_ADDR);
  end

  // Read issue, address counter and the read-valid tag pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      addr_cnt  <= '0;
      tag_pipe  <= '0;
      inflight  <= '0;
    end else begin
      mem_ren  <= issue;
      tag_pipe <= MEM_LATENCY'({tag_pipe, mem_ren});
      inflight <= inflight + CW'(issue) - CW'(push);
      if (issue) begin
        mem_raddr <= addr_cnt;
        addr_cnt  <= frame_issued ? '0 : addr_cnt + ADDR_W'(1);
      end
    end
  end

  assign push = tag_pipe[MEM_LATENCY-1];
  assign pop  = pixel_stream_dout_valid && pixel_stream_dout_ready;

  // NOTE: the storage array is deliberately not reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  assign pixel_stream_dout_valid = (fifo_count != '0);
  assign pixel_stream_dout       = pixel_stream_dout_valid ? fifo_mem[rd_ptr] : '0;

  // Output pixel counter runs independently of the read address so frame_done tracks delivery.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && (pix_cnt == LAST_ADDR);
      if (pop) pix_cnt <= (pix_cnt == LAST_ADDR) ? '0 : pix_cnt + ADDR_W'(1);
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_count == CW'(FIFO_DEPTH)));

`ifdef UNDERFLOW_CNT_EN
  localparam int GW = $clog2(MEM_LATENCY + 2);
  localparam logic [GW-1:0] GUARD_MAX = GW'(MEM_LATENCY + 1);

  logic [GW-1:0] guard_cnt;

  // The first MEM_LATENCY+1 busy cycles are pipeline fill, not starvation.
  always_ff @(posedge clk) begin
    if (rst) begin
      guard_cnt       <= '0;
      underflow_count <= '0;
    end else begin
      if (state == IDLE)            guard_cnt <= '0;
      else if (guard_cnt != GUARD_MAX) guard_cnt <= guard_cnt + GW'(1);
      if (busy && pixel_stream_dout_ready && !pixel_stream_dout_valid &&
          guard_cnt == GUARD_MAX && underflow_count != 16'hFFFF)
        underflow_count <= underflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_framebuffer_reader.sv
// Randomized self-checking bench for framebuffer_reader with a 4x2 image and a fixed-latency RAM model.
module tb_framebuffer_reader;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int ADDR_W = 20;
  localparam int LAT = 2;
  localparam int DEPTH = 8;
  localparam int TOTAL = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [23:0]       mem_rdata = 24'hFFFFFF;
  logic [23:0]       pixel_stream_dout;
  logic              pixel_stream_dout_valid;
  logic              pixel_stream_dout_ready = 1'b0;
  logic              frame_done;
  logic              busy;
`ifdef UNDERFLOW_CNT_EN
  logic [15:0]       underflow_count;
`endif

  always #5 clk = ~clk;

  framebuffer_reader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .MEM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .mem_ren(mem_ren),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .pixel_stream_dout(pixel_stream_dout),
    .pixel_stream_dout_valid(pixel_stream_dout_valid),
    .pixel_stream_dout_ready(pixel_stream_dout_ready),
    .frame_done(frame_done),
    .busy(busy)
`ifdef UNDERFLOW_CNT_EN
    ,
    .underflow_count(underflow_count)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // RAM model: data equals address, presented exactly LAT cycles after the strobe cycle.
  logic        req_v [LAT+1];
  logic [23:0] req_a [LAT+1];
  initial for (int k = 0; k <= LAT; k++) begin req_v[k] = 1'b0; req_a[k] = '0; end

  always @(negedge clk) begin
    for (int k = LAT; k >= 1; k--) begin
      req_v[k] = req_v[k-1];
      req_a[k] = req_a[k-1];
    end
    req_v[0] = mem_ren;
    req_a[0] = 24'(mem_raddr);
    mem_rdata = req_v[LAT] ? req_a[LAT] : 24'hFFFFFF;
  end

  // Consumer: 0 = stalled, 1 = always ready, 2 = random.
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       pixel_stream_dout_ready = 1'b1;
      2:       pixel_stream_dout_ready = 1'($urandom_range(0, 1));
      default: pixel_stream_dout_ready = 1'b0;
    endcase
  end

  // Reference model: expected read address and pixel follow raster order modulo the frame size.
  int    issued = 0;
  int    accepted = 0;
  int    fd_seen = 0;
  logic  fd_exp = 1'b0;
  logic  prev_stall = 1'b0;
  logic [23:0] prev_dout = '0;
  time   last_ren_t = 0;

  always @(negedge clk) begin
    if (rst) begin
      issued = 0;
      accepted = 0;
      fd_exp = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_done", frame_done, fd_exp);
      if (frame_done) fd_seen++;
      if (prev_stall) begin
        check("hold_valid", pixel_stream_dout_valid, 1);
        check("hold_data", pixel_stream_dout, prev_dout);
      end
      if (mem_ren) begin
        check("raddr", mem_raddr, issued % TOTAL);
        issued++;
        check("credit", (issued - accepted) <= DEPTH, 1);
        last_ren_t = $time;
      end
      fd_exp = 1'b0;
      if (pixel_stream_dout_valid && pixel_stream_dout_ready) begin
        check("pixel", pixel_stream_dout, accepted % TOTAL);
        fd_exp = ((accepted % TOTAL) == TOTAL - 1);
        accepted++;
      end
      prev_stall = pixel_stream_dout_valid && !pixel_stream_dout_ready;
      prev_dout = pixel_stream_dout;
    end
  end

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && !pixel_stream_dout_valid) done = 1'b1;
    end
    check("idle_reached", done, 1);
  endtask

  task automatic drive(input logic en);
    @(posedge clk); #1;
    enable = en;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int iss0, acc0, fd0;
    bit seen;
    time t_first;

    // Reset held with enable high: every output stays at zero.
    enable = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      check("rst_mem_ren", mem_ren, 0);
      check("rst_raddr", mem_raddr, 0);
      check("rst_valid", pixel_stream_dout_valid, 0);
      check("rst_dout", pixel_stream_dout, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_busy", busy, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); check("first_ren_c0", mem_ren, 0);
    @(negedge clk); check("first_ren_c1", mem_ren, 0);
    @(negedge clk); check("first_ren_c2", mem_ren, 1);

    // Single frame.
    drive(1'b0);
    wait_idle(100);
    check("single_issued", issued, TOTAL);
    check("single_accepted", accepted, TOTAL);
    check("single_fd", fd_seen, 1);

    // Backpressure with enable held: credits cap reads at the FIFO depth.
    iss0 = issued; acc0 = accepted; fd0 = fd_seen;
    ready_mode = 0;
    drive(1'b1);
    repeat (20) @(negedge clk);
    check("bp_issued", issued - iss0, DEPTH);
    check("bp_full_valid", pixel_stream_dout_valid, 1);
    ready_mode = 1;
    drive(1'b0);
    wait_idle(200);
    check("bp_issued_total", issued - iss0, 2 * TOTAL);
    check("bp_accepted", accepted - acc0, 2 * TOTAL);
    check("bp_fd", fd_seen - fd0, 2);

    // Continuous streaming for three frames with no gaps in the read strobe.
    iss0 = issued; acc0 = accepted; fd0 = fd_seen;
    ready_mode = 1;
    drive(1'b1);
    seen = 1'b0;
    t_first = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_ren) begin seen = 1'b1; t_first = $time; end
    end
    check("cont_start", seen, 1);
    for (int i = 0; i < 100 && (issued - iss0) < 20; i++) @(negedge clk);
    drive(1'b0);
    wait_idle(200);
    check("cont_issued", issued - iss0, 3 * TOTAL);
    check("cont_accepted", accepted - acc0, 3 * TOTAL);
    check("cont_fd", fd_seen - fd0, 3);
    check("cont_no_gap", 32'((last_ren_t - t_first) / 10 + 1), 3 * TOTAL);

    // Enable dropped after pixel 3 is issued; random consumer.
    iss0 = issued; acc0 = accepted; fd0 = fd_seen;
    ready_mode = 2;
    drive(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mem_ren && mem_raddr == ADDR_W'(3)) seen = 1'b1;
    end
    check("drop_saw_addr3", seen, 1);
    drive(1'b0);
    wait_idle(300);
    repeat (5) @(negedge clk);
    check("drop_issued", issued - iss0, TOTAL);
    check("drop_accepted", accepted - acc0, TOTAL);
    check("drop_fd", fd_seen - fd0, 1);
    check("drop_no_ren", mem_ren, 0);

    // Reset mid-frame with reads in flight: returning data must be discarded.
    ready_mode = 0;
    iss0 = issued;
    drive(1'b1);
    for (int i = 0; i < 50 && (issued - iss0) < 3; i++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("mid_rst_valid", pixel_stream_dout_valid, 0);
      check("mid_rst_busy", busy, 0);
    end
    ready_mode = 1;
    drive(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pixel_stream_dout_valid) begin
        seen = 1'b1;
        check("post_rst_first_pixel", pixel_stream_dout, 0);
      end
    end
    check("post_rst_valid_seen", seen, 1);
    drive(1'b0);
    wait_idle(200);
    check("post_rst_accepted", accepted, TOTAL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_reader.md
Name: framebuffer_reader

Overview:
Fetches pixels from a fixed-latency framebuffer RAM in raster order and delivers them as a 24-bit valid/ready pixel stream. The display controller's pixel_stream_din port consumes this stream. The block schedules RAM reads using a credit scheme so that it never overruns its internal prefetch FIFO. It also sequences whole frames: start, continuous repeat, and stop at a frame boundary.

Parameters:
IMG_W, 800, pixels per line.
IMG_H, 600, lines per frame.
ADDR_W, 20, RAM word-address width; IMG_W*IMG_H must not exceed 2**ADDR_W.
MEM_LATENCY, 2, fixed cycles from mem_ren to mem_rdata valid; must be >= 1.
FIFO_DEPTH, 8, prefetch FIFO entries; must be a power of 2 and >= MEM_LATENCY+1.

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
enable  input  1  level; request frame streaming.
mem_ren  output  1  RAM read strobe.
mem_raddr  output  ADDR_W  RAM read word address.
mem_rdata  input  24  RAM read data, valid exactly MEM_LATENCY cycles after mem_ren.
pixel_stream_dout  output  24  pixel {R,G,B}.
pixel_stream_dout_valid  output  1  pixel available.
pixel_stream_dout_ready  input  1  consumer accepts.
frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE; FIFO emptied; in-flight read pipeline cleared, so returning data is discarded. mem_ren=0, mem_raddr=0, pixel_stream_dout_valid=0, pixel_stream_dout=0, frame_done=0, busy=0. Address counter=0.
- States:
  - IDLE: if enable=1, go to FETCH on the next cycle.
  - FETCH: issue reads.
  - DRAIN: no new reads; wait for outstanding data to be delivered.
- Issue rule (FETCH only): mem_ren=1 in a cycle only if fifo_count + inflight < FIFO_DEPTH.
  - inflight is the number of reads issued whose data has not yet returned.
  - Throughput is one read per cycle when the consumer keeps up.
  - A pop in the same cycle does not add credit until the next cycle (registered count).
- Address: linear counter starting at 0, incremented by 1 per issued read. No multiplier.
  - The issue of address IMG_W*IMG_H-1 marks frame-issue-complete, and the counter wraps to 0.
  - If enable=1 at that cycle, stay in FETCH and continue with the next frame, with no gap cycle.
  - Otherwise go to DRAIN.
- Return path: a MEM_LATENCY-deep shift register carries the read-valid tag. When the tag exits, mem_rdata is pushed into the FIFO. The credit rule guarantees the push never overflows; overflow is a design error.
- Output: pixel_stream_dout_valid = FIFO not empty, and pixel_stream_dout = FIFO head, combinationally from registered state.
  - Pop on valid & ready.
  - Data must be held stable while valid=1 and ready=0.
- Push and pop in the same cycle are allowed, including on an empty FIFO: data written this cycle is visible next cycle, with no fall-through.
- frame_done: registered. It pulses the cycle after the pop of a frame's pixel index IMG_W*IMG_H-1. An output pixel counter tracks this independently of the address counter.
- DRAIN -> IDLE when inflight=0 and the FIFO is empty, one cycle after the final pop. enable rising during DRAIN is ignored until IDLE.
- enable dropping mid-frame: the current frame is always completed, then the block goes to DRAIN. Frames are never truncated.
- Reset mid-frame: immediate return to the reset state. The next frame after reset starts at address 0.

Optional Feature:
UNDERFLOW_CNT_EN:
- When defined: adds output port underflow_count (16 bits, reset 0). It increments, saturating at 16'hFFFF, on each cycle where busy=1, pixel_stream_dout_ready=1, and pixel_stream_dout_valid=0, excluding the first MEM_LATENCY+1 cycles after leaving IDLE.
- When not defined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst 5 cycles with enable=1 -> all outputs 0 and state IDLE throughout. First mem_ren appears 2 cycles after rst falls (IDLE -> FETCH, then issue).
- Single frame: IMG_W=4, IMG_H=2, MEM_LATENCY=2; RAM model returns data=address; enable=1 for 3 cycles then 0; ready=1 -> stream 0..7 in order, each accepted exactly once. frame_done pulses once after pixel 7; busy falls after drain.
- Backpressure: same setup, ready=0 for 20 cycles -> at most FIFO_DEPTH=8 mem_ren pulses total and the FIFO holds 8; on release, 0..7 are delivered with no loss or duplication, and dout stays stable while stalled.
- Continuous: enable held at 1 for 3 frames -> addresses 0..7,0..7,0..7 with no idle gap in mem_ren. Exactly 3 frame_done pulses, each 8 pops apart.
- Enable drop mid-frame: deassert enable after pixel 3 is issued -> pixels 4..7 are still issued and delivered, then IDLE. No reads from the next frame.
- Reset mid-frame: assert rst with 3 reads in flight -> returning data is discarded and valid=0. After re-enable, the first pixel output is data 0.
